// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the packed-MAC sequencer.
// The DSP slice holds 4 lanes of 14 bits (10-bit products plus 4 bits of accumulation headroom).
package mac_seq_pkg;

    localparam int unsigned DefaultMultLat = 3;
    localparam int unsigned LaneWidth      = 14;
    localparam int unsigned NumLanes       = 4;
    localparam int unsigned PeOutWidth     = LaneWidth * NumLanes;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StOutput
    } state_e;

endpackage

// File: rtl/en_delay_line.sv
// Enable shift register with asynchronous clear; tap is the input delayed by DEPTH cycles.
// Used to align a beat-accept strobe with a pipelined DSP multiplier output.
module en_delay_line #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic tap
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign tap = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_dsp_18_seq.sv
// Sequencer for a packed signed MAC DSP slice: clear, K operand beats, pipeline drain,
// then a valid/ready hand-off of the captured accumulator.
module mac_dsp_18_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned MULT_LAT     = DefaultMultLat,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PE_OUT_WIDTH = PeOutWidth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    mac_clr,
    output logic                    mac_en,
    input  logic [PE_OUT_WIDTH-1:0] acc_in,
    output logic [PE_OUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    done
);

    localparam logic [CNT_W-1:0] DrainLast = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] One       = CNT_W'(1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [PE_OUT_WIDTH-1:0] data_q, data_d;
    logic                    done_q, done_d;
    logic                    fire;

    assign fire = in_valid & in_ready;

    // The beat counter is reused to time the drain once all beats are in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        cnt_d   = '0;
                        state_d = StClear;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StClear: state_d = StFeed;
            StFeed: begin
                if (fire) begin
                    if (cnt_q == k_q - One) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    data_d  = acc_in;
                    state_d = StOutput;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    en_delay_line #(
        .DEPTH(MULT_LAT)
    ) u_en_delay (
        .clk  (clk),
        .reset(reset),
        .din  (fire),
        .tap  (mac_en)
    );

    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StFeed);
    assign mac_clr   = (state_q == StClear);
    assign out_valid = (state_q == StOutput);
    assign out_data  = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mac_dsp_18_seq.sv
// Randomized bench for mac_dsp_18_seq: a job timeline model tracks fires and the expected
// capture value, and every cycle is compared against it.
module tb_mac_dsp_18_seq;

    localparam int ML = 3;
    localparam int CW = 16;
    localparam int W  = 56;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [CW-1:0] k_len;
    logic [W-1:0]  acc_in, out_data;
    logic          busy, in_ready, mac_clr, mac_en, out_valid, done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mac_dsp_18_seq #(
        .MULT_LAT    (ML),
        .CNT_W       (CW),
        .PE_OUT_WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .k_len    (k_len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .acc_in   (acc_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        acc_in = W'({$urandom(), $urandom()});
    endtask

    // One full job. vmode: 0 = in_valid always, 1 = 1,0,1,0..., 2 = random.
    // Cycle 0 is the start cycle; a fire at cycle c must show as mac_en at cycle c+ML.
    task automatic run_job(input int k, input int vmode, input int rdelay, input bit poke,
                           input bit prestarted, input bit start_next, input int k_next,
                           input string tag);
        bit           fired [0:1023];
        int           cyc;
        int           nf;
        logic [W-1:0] exp_data;
        logic         e_en;
        for (int i = 0; i < 1024; i++) fired[i] = 1'b0;
        exp_data = '0;
        if (!prestarted) begin
            start = 1'b1;
            k_len = CW'(k);
        end
        step();
        cyc      = 1;
        start    = 1'b0;
        k_len    = CW'($urandom());
        in_valid = 1'($urandom_range(0, 1));
        n_total++; if (mac_clr !== 1'b1) $display("FAIL %s clear: mac_clr got %b want 1", tag, mac_clr); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL %s clear: in_ready got %b want 0", tag, in_ready); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL %s clear: busy got %b want 1", tag, busy); else n_pass++;
        n_total++; if (mac_en !== 1'b0) $display("FAIL %s clear: mac_en got %b want 0", tag, mac_en); else n_pass++;
        step();
        cyc = 2;
        nf  = 0;
        while (nf < k) begin
            if (cyc > 1000) begin
                n_total++;
                $display("FAIL %s feed timeout: fires got %0d want %0d", tag, nf, k);
                return;
            end
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(((cyc - 2) % 2) == 0)
                                                          : 1'($urandom_range(0, 1));
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            k_len = CW'($urandom());
            e_en  = (cyc >= ML) && fired[cyc-ML];
            n_total++; if (in_ready !== 1'b1) $display("FAIL %s feed c%0d: in_ready got %b want 1", tag, cyc, in_ready); else n_pass++;
            n_total++; if (mac_en !== e_en) $display("FAIL %s feed c%0d: mac_en got %b want %b", tag, cyc, mac_en, e_en); else n_pass++;
            n_total++; if (mac_clr !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL %s feed c%0d: clr/ov/busy got %b%b%b want 001", tag, cyc, mac_clr, out_valid, busy);
            else n_pass++;
            if (in_valid) begin
                fired[cyc] = 1'b1;
                nf++;
            end
            step();
            cyc++;
        end
        for (int d = 0; d <= ML; d++) begin
            in_valid = 1'($urandom_range(0, 1));
            start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            k_len    = CW'($urandom());
            e_en     = fired[cyc-ML];
            n_total++; if (mac_en !== e_en) $display("FAIL %s drain c%0d: mac_en got %b want %b", tag, cyc, mac_en, e_en); else n_pass++;
            n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL %s drain c%0d: rdy/ov/busy got %b%b%b want 001", tag, cyc, in_ready, out_valid, busy);
            else n_pass++;
            if (d == ML) exp_data = acc_in;
            step();
            cyc++;
        end
        for (int r = 0; r <= rdelay; r++) begin
            out_ready = (r == rdelay);
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            n_total++; if (out_valid !== 1'b1) $display("FAIL %s output c%0d: out_valid got %b want 1", tag, cyc, out_valid); else n_pass++;
            n_total++; if (out_data !== exp_data) $display("FAIL %s output c%0d: out_data got %h want %h", tag, cyc, out_data, exp_data); else n_pass++;
            n_total++; if (busy !== 1'b1 || done !== 1'b0 || mac_en !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL %s output c%0d: busy/done/en/rdy got %b%b%b%b want 1000", tag, cyc, busy, done, mac_en, in_ready);
            else n_pass++;
            step();
            cyc++;
        end
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL %s done cycle: done got %b want 1", tag, done); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s done cycle: ov/busy got %b%b want 00", tag, out_valid, busy);
        else n_pass++;
        if (start_next) begin
            start = 1'b1;
            k_len = CW'(k_next);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_total++; if ({busy, in_ready, mac_clr, mac_en, out_valid, done} !== 6'b0)
            $display("FAIL reset: flags got %b want 000000", {busy, in_ready, mac_clr, mac_en, out_valid, done});
        else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset: out_data got %h want 0", out_data); else n_pass++;
    endtask

    task automatic test_basic();
        run_job(4, 0, 0, 1'b0, 1'b0, 1'b0, 0, "basic");
        step();
    endtask

    task automatic test_bubbles();
        run_job(3, 1, 0, 1'b0, 1'b0, 1'b0, 0, "bubbles");
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        step();
        run_job(5, 2, 5, 1'b0, 1'b0, 1'b0, 0, "backpressure");
        step();
    endtask

    task automatic test_zero_len();
        start = 1'b1;
        k_len = '0;
        step();
        start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL zero_len: done got %b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0 || mac_clr !== 1'b0) $display("FAIL zero_len: busy/clr got %b%b want 00", busy, mac_clr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if ({done, mac_clr, mac_en, out_valid, busy} !== 5'b0)
                $display("FAIL zero_len idle %0d: flags got %b want 00000", i, {done, mac_clr, mac_en, out_valid, busy});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_feed();
        start = 1'b1;
        k_len = CW'(6);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        n_total++; if ({busy, in_ready, mac_clr, mac_en, out_valid, done} !== 6'b0)
            $display("FAIL reset_mid: flags got %b want 000000", {busy, in_ready, mac_clr, mac_en, out_valid, done});
        else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_mid: out_data got %h want 0", out_data); else n_pass++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_total++; if (mac_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_mid after %0d: en/rdy/busy got %b%b%b want 000", i, mac_en, in_ready, busy);
            else n_pass++;
        end
        in_valid = 1'b0;
        run_job(4, 2, 0, 1'b0, 1'b0, 1'b0, 0, "after_reset");
        step();
    endtask

    task automatic test_back_to_back();
        run_job(6, 2, 1, 1'b1, 1'b0, 1'b1, 5, "b2b_first");
        run_job(5, 0, 0, 1'b1, 1'b1, 1'b0, 0, "b2b_second");
        step();
    endtask

    task automatic test_random();
        for (int j = 0; j < 10; j++) begin
            run_job(int'($urandom_range(1, 12)), 2, int'($urandom_range(0, 3)), 1'b1, 1'b0,
                    1'b0, 0, "random");
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        step();
        test_basic();
        test_bubbles();
        test_backpressure();
        test_zero_len();
        test_reset_mid_feed();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
